// File: rtl/dif_multi_chip_ta_scan.sv
// Multi-chip automatic trigger-threshold scan controller for the ECAL DIF.
// Optional SC/trigger watchdog: define SCAN_TIMEOUT_EN.
module dif_multi_chip_ta_scan #(
    parameter int N_CHIP  = 4,
    parameter int DAC_W   = 10,
    parameter int CNT_W   = 12,
    parameter int HIT_WIN = 8
) (
    input  logic                     Clk_10MHz,
    input  logic                     Rst,
    input  logic                     In_Start_Scan,
    input  logic                     In_Abort,
    input  logic [N_CHIP-1:0]        In_Chip_En,
    input  logic [DAC_W-1:0]         In_Ini_DAC,
    input  logic [DAC_W-1:0]         In_End_DAC,
    input  logic [DAC_W-1:0]         In_Step,
    input  logic [CNT_W-1:0]         In_Trig_Num,
    input  logic                     In_Trig_Ex,
    input  logic                     In_Hit,
    input  logic                     In_Finish_Sc,
    input  logic                     In_Fifo_Full,
    output logic                     Out_Set_SC,
    output logic [N_CHIP-1:0]        Out_Chip_Sel,
    output logic [N_CHIP*DAC_W-1:0]  Out_Set_DAC,
    output logic [15:0]              Out_Fifo_Din,
    output logic                     Out_Fifo_Wr,
    output logic                     Out_Busy,
    output logic                     Out_Finish_Scan,
    output logic [CNT_W-1:0]         Out_Test_Cnt_Hit
);

    localparam int IDX_W = 5;
    localparam int WIN_W = $clog2(HIT_WIN + 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SEL     = 4'd1;
    localparam logic [3:0] S_SET_SC  = 4'd2;
    localparam logic [3:0] S_WAIT_SC = 4'd3;
    localparam logic [3:0] S_COUNT   = 4'd4;
    localparam logic [3:0] S_WR_HDR  = 4'd5;
    localparam logic [3:0] S_WR_CNT  = 4'd6;
    localparam logic [3:0] S_NEXT    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;
    localparam logic [3:0] S_WR_TO   = 4'd9;

    logic [3:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [N_CHIP-1:0] r_chip_sel;
    logic [DAC_W-1:0]  r_dac [N_CHIP];
    logic [DAC_W-1:0]  r_cur_dac;
    logic [CNT_W-1:0]  r_trig_cnt;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic              r_hit_taken;
    logic [2:0]        r_trig_sync;
    logic [2:0]        r_hit_sync;
    logic [2:0]        r_start_sync;

    logic              w_trig_edge;
    logic              w_hit_edge;
    logic              w_start_edge;
    logic [DAC_W-1:0]  w_step_eff;
    logic [CNT_W-1:0]  w_trig_target;
    logic [DAC_W:0]    w_sum;
    logic              w_last_point;
    logic              w_found;
    logic [IDX_W-1:0]  w_found_idx;
    logic [N_CHIP-1:0] w_found_oh;
    logic [3:0]        w_chip_id;
    logic              w_wr_state;
    logic              w_fifo_wr;
    logic              w_count_done;
    logic              w_timeout;

    // Two flops of metastability protection, third flop for edge detection
    always_ff @(posedge Clk_10MHz or posedge Rst) begin
        if (Rst) begin
            r_trig_sync  <= '0;
            r_hit_sync   <= '0;
            r_start_sync <= '0;
        end else begin
            r_trig_sync  <= {r_trig_sync[1:0], In_Trig_Ex};
            r_hit_sync   <= {r_hit_sync[1:0], In_Hit};
            r_start_sync <= {r_start_sync[1:0], In_Start_Scan};
        end
    end

    assign w_trig_edge  = r_trig_sync[1] & ~r_trig_sync[2];
    assign w_hit_edge   = r_hit_sync[1] & ~r_hit_sync[2];
    assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];

    assign w_step_eff    = (In_Step == '0) ? DAC_W'(1) : In_Step;
    assign w_trig_target = (In_Trig_Num == '0) ? CNT_W'(1) : In_Trig_Num;
    assign w_sum         = {1'b0, r_cur_dac} + {1'b0, w_step_eff};
    assign w_last_point  = w_sum[DAC_W] || (w_sum[DAC_W-1:0] > In_End_DAC);
    assign w_chip_id     = r_idx[3:0];

    // The final trigger's window must close before the point is reported
    assign w_count_done = (r_trig_cnt >= w_trig_target) && (r_win_cnt == '0) && !w_trig_edge;

    // Lowest enabled chip at or above the current index; single-cycle search
    always_comb begin
        w_found     = 1'b0;
        w_found_idx = '0;
        for (int i = N_CHIP - 1; i >= 0; i--) begin
            if (In_Chip_En[i] && (IDX_W'(i) >= r_idx)) begin
                w_found     = 1'b1;
                w_found_idx = IDX_W'(i);
            end
        end
    end

    assign w_found_oh = N_CHIP'(1) << w_found_idx;

    assign w_wr_state = (r_state == S_WR_HDR) || (r_state == S_WR_CNT) || (r_state == S_WR_TO);
    assign w_fifo_wr  = w_wr_state && !In_Fifo_Full && !In_Abort;

`ifdef SCAN_TIMEOUT_EN
    logic [19:0] r_wdog;

    always_ff @(posedge Clk_10MHz or posedge Rst) begin
        if (Rst) begin
            r_wdog <= '0;
        end else if (!In_Abort && !w_timeout &&
                     (((r_state == S_WAIT_SC) && !In_Finish_Sc) ||
                      ((r_state == S_COUNT) && !w_trig_edge))) begin
            r_wdog <= r_wdog + 20'd1;
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_timeout = (r_wdog == '1);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge Clk_10MHz or posedge Rst) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_chip_sel  <= '0;
            r_cur_dac   <= '0;
            r_trig_cnt  <= '0;
            r_hit_cnt   <= '0;
            r_win_cnt   <= '0;
            r_hit_taken <= 1'b0;
            for (int i = 0; i < N_CHIP; i++) r_dac[i] <= '0;
        end else if ((r_state != S_IDLE) && In_Abort) begin
            r_state    <= S_IDLE;
            r_chip_sel <= '0;
            r_win_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        for (int i = 0; i < N_CHIP; i++) r_dac[i] <= In_Ini_DAC;
                        r_idx   <= '0;
                        r_state <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (w_found) begin
                        r_idx      <= w_found_idx;
                        r_chip_sel <= w_found_oh;
                        r_cur_dac  <= In_Ini_DAC;
                        for (int i = 0; i < N_CHIP; i++) begin
                            if (IDX_W'(i) == w_found_idx) r_dac[i] <= In_Ini_DAC;
                        end
                        r_state <= S_SET_SC;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_SET_SC: r_state <= S_WAIT_SC;
                S_WAIT_SC: begin
                    if (w_timeout) begin
                        r_state <= S_WR_TO;
                    end else if (In_Finish_Sc) begin
                        r_trig_cnt  <= '0;
                        r_hit_cnt   <= '0;
                        r_win_cnt   <= '0;
                        r_hit_taken <= 1'b0;
                        r_state     <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_timeout) begin
                        r_state <= S_WR_TO;
                    end else if (w_trig_edge) begin
                        // A hit coinciding with the trigger edge belongs to no window
                        if (r_trig_cnt != '1) r_trig_cnt <= r_trig_cnt + CNT_W'(1);
                        r_win_cnt   <= WIN_W'(HIT_WIN);
                        r_hit_taken <= 1'b0;
                    end else begin
                        if (r_win_cnt != '0) begin
                            r_win_cnt <= r_win_cnt - WIN_W'(1);
                            if (w_hit_edge && !r_hit_taken) begin
                                r_hit_taken <= 1'b1;
                                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                            end
                        end
                        if (w_count_done) r_state <= S_WR_HDR;
                    end
                end
                S_WR_HDR: if (w_fifo_wr) r_state <= S_WR_CNT;
                S_WR_CNT: if (w_fifo_wr) r_state <= S_NEXT;
                S_WR_TO:  if (w_fifo_wr) r_state <= S_NEXT;
                S_NEXT: begin
                    if (w_last_point) begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_SEL;
                    end else begin
                        r_cur_dac <= w_sum[DAC_W-1:0];
                        for (int i = 0; i < N_CHIP; i++) begin
                            if (IDX_W'(i) == r_idx) r_dac[i] <= w_sum[DAC_W-1:0];
                        end
                        r_state <= S_SET_SC;
                    end
                end
                S_DONE: begin
                    r_chip_sel <= '0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Out_Fifo_Din = 16'h0000;
        case (r_state)
            S_WR_HDR: Out_Fifo_Din = {2'b10, w_chip_id, 10'(r_cur_dac)};
            S_WR_CNT: Out_Fifo_Din = {2'b11, 14'(r_hit_cnt)};
            S_WR_TO:  Out_Fifo_Din = {2'b01, w_chip_id, 10'h3FF};
            default:  Out_Fifo_Din = 16'h0000;
        endcase
    end

    // Chip 0 occupies the most significant DAC field
    always_comb begin
        Out_Set_DAC = '0;
        for (int i = 0; i < N_CHIP; i++) begin
            Out_Set_DAC[(N_CHIP-1-i)*DAC_W +: DAC_W] = r_dac[i];
        end
    end

    assign Out_Set_SC       = (r_state == S_SET_SC);
    assign Out_Busy         = (r_state != S_IDLE);
    assign Out_Finish_Scan  = (r_state == S_DONE);
    assign Out_Chip_Sel     = r_chip_sel;
    assign Out_Fifo_Wr      = w_fifo_wr;
    assign Out_Test_Cnt_Hit = r_hit_cnt;

endmodule

// File: doc/dif_multi_chip_ta_scan.md
Name: dif_multi_chip_ta_scan

Overview:
Parametrised successor to the four-chip auto trigger-threshold scan controller on the ECAL DIF.
- Sequences a threshold scan automatically across up to N_CHIP SKIROC2 chips, one chip at a time. For each chip it steps the DAC from a start value to an end value.
- At each DAC point it reloads slow control, then counts hits over a programmable number of external triggers.
- It writes a two-word result record per point to the readout FIFO.
- Adds behaviour the previous block lacks: chip-enable skipping, programmable end value and step, FIFO back-pressure, and abort.

Parameters:
N_CHIP, 4, number of chips scanned (1..16).
DAC_W, 10, threshold DAC width per chip (1..10).
CNT_W, 12, hit/trigger counter width (1..14).
HIT_WIN, 8, cycles after a trigger edge during which a hit edge is counted.

Ports:
Clk_10MHz  in  1  system clock.
Rst  in  1  asynchronous reset, active-high.
In_Start_Scan  in  1  start request; rising edge is effective.
In_Abort  in  1  level; aborts the scan.
In_Chip_En  in  N_CHIP  bit i enables chip i.
In_Ini_DAC  in  DAC_W  first DAC value.
In_End_DAC  in  DAC_W  last DAC value.
In_Step  in  DAC_W  DAC increment; a value of 0 is treated as 1.
In_Trig_Num  in  CNT_W  triggers per point; a value of 0 is treated as 1.
In_Trig_Ex  in  1  external trigger, asynchronous; rising edge is effective.
In_Hit  in  1  SKIROC hit, asynchronous; rising edge is effective.
In_Finish_Sc  in  1  slow-control load done, high for at least 1 cycle.
In_Fifo_Full  in  1  readout FIFO full.
Out_Set_SC  out  1  one-cycle slow-control load request.
Out_Chip_Sel  out  N_CHIP  one-hot active chip; 0 when idle.
Out_Set_DAC  out  N_CHIP*DAC_W  per-chip DAC; chip 0 occupies the MSB field.
Out_Fifo_Din  out  16  record word.
Out_Fifo_Wr  out  1  FIFO write strobe.
Out_Busy  out  1  scan in progress.
Out_Finish_Scan  out  1  one-cycle pulse at normal completion.
Out_Test_Cnt_Hit  out  CNT_W  live hit count of the current point.

Behaviour:
- Reset values: all outputs 0, all DAC fields 0, FSM in IDLE.
- Input synchronisation:
  - In_Trig_Ex and In_Hit each pass through a 2-FF synchroniser, then an edge detector.
  - In_Start_Scan passes through the same 2-stage delay plus edge detect.
- State machine:
  - IDLE: on a start edge, load every DAC field with In_Ini_DAC, set chip index to 0, assert Out_Busy, go to SEL.
    - A start edge while not in IDLE is ignored.
  - SEL: search from the current index for the first enabled chip.
    - Found: set Out_Chip_Sel to that chip's one-hot, set its DAC field to In_Ini_DAC, go to SET_SC.
    - None left: go to DONE.
    - The search takes at most N_CHIP cycles.
  - SET_SC: drive Out_Set_SC high for exactly 1 cycle, go to WAIT_SC.
  - WAIT_SC: wait for In_Finish_Sc to be high; then clear the hit and trigger counters and go to COUNT.
  - COUNT: on each trigger edge, increment the trigger counter and open a window of HIT_WIN cycles.
    - The first hit edge inside the window increments the hit counter. At most one hit is counted per trigger.
    - A new trigger edge restarts the window.
    - The hit counter saturates at all-ones.
    - When trigger count reaches In_Trig_Num, go to WR_HDR. The hit counted in the final trigger's window is included: the transition occurs after the window closes.
  - WR_HDR: write {2'b10, chip_id[3:0], DAC zero-extended to 10 bits}, then go to WR_CNT.
  - WR_CNT: write {2'b11, hit count zero-extended to 14 bits}, then go to NEXT.
  - NEXT: if DAC + In_Step > In_End_DAC, or the addition carries out of DAC_W, increment the chip index and go to SEL. Otherwise add In_Step to the DAC field and go to SET_SC.
    - The addition is done at DAC_W+1 bits.
    - If In_Ini_DAC > In_End_DAC, exactly one point (In_Ini_DAC) is scanned per chip.
  - DONE: pulse Out_Finish_Scan for 1 cycle, clear Out_Busy and Out_Chip_Sel, return to IDLE.
- FIFO handshake:
  - Out_Fifo_Wr is high only in WR_HDR/WR_CNT, and only when In_Fifo_Full is 0.
  - While full, the FSM holds state with Out_Fifo_Wr low.
  - A word counts as written in the cycle Out_Fifo_Wr is high.
  - Out_Fifo_Din is stable while the FSM holds in the write state.
- Abort: In_Abort high in any non-IDLE state causes, on the next edge:
  - IDLE, with Out_Busy, Out_Chip_Sel, Out_Set_SC and Out_Fifo_Wr all 0;
  - no Out_Finish_Scan pulse;
  - DAC fields hold their values;
  - a partially written record is not completed.
- Reset mid-scan returns the block immediately to the reset values.
- Out_Test_Cnt_Hit mirrors the hit counter register, with zero latency.

Optional Feature:
SCAN_TIMEOUT_EN:
- Defined: a 20-bit watchdog runs in WAIT_SC and COUNT and is cleared on every state entry and every trigger edge.
- Reaching 2^20-1 (about 105 ms) writes a single word {2'b01, chip_id, 10'h3FF} with the same FIFO handshake, then goes to NEXT.
- Not defined: no watchdog; WAIT_SC and COUNT may wait indefinitely.

Test Plan:
1. N_CHIP=4, Chip_En=4'b1111, Ini=100, End=102, Step=1, Trig_Num=3, one hit per trigger, In_Finish_Sc 2 cycles after each Set_SC -> 12 Set_SC pulses and 24 FIFO words. First record is 16'h8064, 16'hC003. Exactly one Out_Finish_Scan pulse; chip 3's DAC field ends at 102.
2. Chip_En=4'b0101 (chips 0 and 2), Ini=End=5 -> records only for chip_id 0 and 2; Out_Chip_Sel never shows chips 1 or 3. Chip_En=0 -> Finish pulse with no Set_SC.
3. Trig_Num=4, hits at 0, 3 and 12 cycles after trigger, plus two hits within a single window -> count = 2 per the window rules. A hit with no trigger is not counted.
4. Hold In_Fifo_Full high for 10 cycles in WR_HDR -> Out_Fifo_Wr stays low and Din stays stable; the word is written in the first cycle after Full drops.
5. Ini=1020, End=1023, Step=3 -> points 1020 and 1023 only, with no wrap. Ini=1022, Step=5 -> single point.
6. Abort asserted during COUNT of chip 1 -> Busy drops on the next edge with no Finish pulse. A new start then rescans from chip 0.
